// File: rtl/ps2_key_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_capture
//  Description : Receive-only PS/2 keyboard front end. Deserialises 11-bit
//                device-to-host frames and filters break, extended and
//                typematic sequences. Presents the two most recent make
//                codes on num1/num2.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_capture #(
    parameter int TIMEOUT = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic       key_valid,
    output logic       frame_err
);

    localparam logic [15:0] c_TMO   = 16'(TIMEOUT - 1);
    localparam logic [7:0]  c_BREAK = 8'hF0;
    localparam logic [7:0]  c_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_clk_sync;   // [1:0] synchroniser, [2] previous sync'd value
    logic [1:0]  r_dat_sync;
    logic [2:0]  r_cnt;
    logic [7:0]  r_shreg;
    logic        r_par;
    logic [15:0] r_tcnt;
    logic        r_brk;
    logic        r_ext;
    logic [7:0]  r_held;

    logic w_fe;
    logic w_dat;
    logic w_tmo;
    logic w_frame_ok;
    logic w_good;
    logic w_bad;

    assign w_fe  = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_dat = r_dat_sync[1];

    // An in-progress frame is abandoned if no falling edge arrives in time;
    // a falling edge in the same cycle wins over the timeout.
    assign w_tmo = !w_fe && (r_state != S_IDLE) && (r_tcnt == c_TMO);

    // Stop bit high and odd parity over data plus parity bit.
    assign w_frame_ok = w_dat && (^{r_shreg, r_par});
    assign w_good     = w_fe && (r_state == S_STOP) && w_frame_ok;
    assign w_bad      = (w_fe && (r_state == S_IDLE) && w_dat)
                      || (w_fe && (r_state == S_STOP) && !w_frame_ok)
                      || w_tmo;

    // Two-stage synchronisers; idle-high reset values avoid a false edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
        end
    end

    // Frame receiver: start / 8 data LSB-first / parity / stop, with timeout.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_shreg <= 8'h00;
            r_par   <= 1'b0;
            r_tcnt  <= 16'd0;
        end else begin
            if (w_fe || (r_state == S_IDLE) || w_tmo) begin
                r_tcnt <= 16'd0;
            end else begin
                r_tcnt <= r_tcnt + 16'd1;
            end

            if (w_tmo) begin
                r_state <= S_IDLE;
                r_cnt   <= 3'd0;
            end else if (w_fe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_dat) begin
                            r_state <= S_DATA;
                            r_cnt   <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        r_shreg <= {w_dat, r_shreg[7:1]};
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= w_dat;
                        r_state <= S_STOP;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Scancode decoder: drops break/extended sequences and typematic repeats.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            num1      <= 8'h00;
            num2      <= 8'h00;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_held    <= 8'h00;
        end else begin
            key_valid <= 1'b0;
            frame_err <= w_bad;
            if (w_bad) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_good) begin
                if (r_shreg == c_BREAK) begin
                    r_brk <= 1'b1;
                end else if (r_shreg == c_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_ext) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else if (r_brk) begin
                    if (r_shreg == r_held) begin
                        r_held <= 8'h00;
                    end
                    r_brk <= 1'b0;
                end else if (r_shreg != r_held) begin
                    num2      <= num1;
                    num1      <= r_shreg;
                    r_held    <= r_shreg;
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_capture
//  Description : Self-checking bench for ps2_key_capture. Table of frames with
//                expected outcomes, scoreboard queue of expected outputs
//                consumed on each key_valid pulse, plus timeout and
//                mid-frame reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_key_capture;

    localparam int c_TO = 1000;

    logic       clk;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] num1;
    logic [7:0] num2;
    logic       key_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int err_cnt = 0;
    logic [15:0] sb_q[$];

    ps2_key_capture #(.TIMEOUT(c_TO)) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .num1      (num1),
        .num2      (num2),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic       kv;
        logic       err;
        logic [7:0] n1;
        logic [7:0] n2;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer and pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (key_valid) begin
                kv_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_key_valid", 32'(key_valid), 32'd0);
                end else begin
                    chk("scoreboard_num", 32'({num1, num2}), 32'(sb_q.pop_front()));
                end
            end
            if (frame_err) err_cnt++;
            if (key_valid && frame_err) chk("kv_and_err_together", 32'd1, 32'd0);
        end
    end

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = b[i];
            #100;
            ps2_clk = 1'b0;
            #100;
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^code) ^ bad_par;
        send_bits({~bad_stop, par, code, 1'b0}, 11);
        #400;
    endtask

    initial begin
        int kv0;
        int err0;

        //              code   bpar  bstop kv    err   n1     n2
        tbl[0]  = '{8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 8'h00};
        tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23, 8'h00};
        tbl[2]  = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23, 8'h00};
        tbl[3]  = '{8'h4B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 8'h23};
        tbl[4]  = '{8'h4B, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 8'h23};
        tbl[5]  = '{8'h4B, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 8'h23};
        tbl[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 8'h23};
        tbl[7]  = '{8'h4B, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 8'h23};
        tbl[8]  = '{8'h4B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 8'h4B};
        tbl[9]  = '{8'h23, 1'b1, 1'b0, 1'b0, 1'b1, 8'h4B, 8'h4B};
        tbl[10] = '{8'h23, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4B, 8'h4B};
        tbl[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 8'h4B};
        tbl[12] = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 8'h4B};
        tbl[13] = '{8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 8'h4B};
        tbl[14] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23, 8'h4B};
        tbl[15] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 8'h4B};
        tbl[16] = '{8'h4B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 8'h23};

        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        #100;
        chk("reset_num1", 32'(num1), 32'h00);
        chk("reset_num2", 32'(num2), 32'h00);
        chk("reset_kv", 32'(key_valid), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        resetn = 1'b1;
        #100;

        for (int i = 0; i < 17; i++) begin
            kv0  = kv_cnt;
            err0 = err_cnt;
            if (tbl[i].kv) sb_q.push_back({tbl[i].n1, tbl[i].n2});
            send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
            chk($sformatf("vec%0d_kv_count", i), 32'(kv_cnt - kv0), 32'(tbl[i].kv));
            chk($sformatf("vec%0d_err_count", i), 32'(err_cnt - err0), 32'(tbl[i].err));
            chk($sformatf("vec%0d_num1", i), 32'(num1), 32'(tbl[i].n1));
            chk($sformatf("vec%0d_num2", i), 32'(num2), 32'(tbl[i].n2));
        end

        // Idle-level bit where a start bit is expected.
        err0 = err_cnt;
        kv0  = kv_cnt;
        send_bits(11'h001, 1);
        #400;
        chk("bad_start_err", 32'(err_cnt - err0), 32'd1);
        chk("bad_start_kv", 32'(kv_cnt - kv0), 32'd0);

        // Partial frame abandoned by the keyboard: start + 4 data bits.
        err0 = err_cnt;
        send_bits({7'd0, 4'b0110}, 5);
        #((c_TO - 20) * 10);
        chk("timeout_not_early", 32'(err_cnt - err0), 32'd0);
        #300;
        chk("timeout_err", 32'(err_cnt - err0), 32'd1);
        kv0 = kv_cnt;
        sb_q.push_back({8'h23, 8'h4B});
        send_frame(8'h23, 1'b0, 1'b0);
        chk("after_timeout_kv", 32'(kv_cnt - kv0), 32'd1);
        chk("after_timeout_num1", 32'(num1), 32'h23);

        // Reset asserted after five data bits of a 0x4B frame.
        send_bits({2'b11, 8'h4B, 1'b0}, 6);
        #50;
        resetn = 1'b0;
        #1;
        chk("midreset_num1", 32'(num1), 32'h00);
        chk("midreset_num2", 32'(num2), 32'h00);
        chk("midreset_kv", 32'(key_valid), 32'd0);
        chk("midreset_err", 32'(frame_err), 32'd0);
        #99;
        resetn = 1'b1;
        #100;
        kv0  = kv_cnt;
        err0 = err_cnt;
        sb_q.push_back({8'h23, 8'h00});
        send_frame(8'h23, 1'b0, 1'b0);
        chk("postreset_kv", 32'(kv_cnt - kv0), 32'd1);
        chk("postreset_err", 32'(err_cnt - err0), 32'd0);
        chk("postreset_num1", 32'(num1), 32'h23);
        chk("postreset_num2", 32'(num2), 32'h00);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
